// File: rtl/dcache_miss_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// dcache_miss_ctrl_pkg : shared state encoding and line-size helper
// Rev 1.0
// ============================================================================
package dcache_miss_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_SINGLE = 2'd2
  } state_e;

  function automatic int unsigned line_words(input int unsigned ls);
    return 32'd1 << ls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_req_counter.sv
`default_nettype none
// ============================================================================
// dcache_req_counter : LS+1 bit up-counter with clear, last and terminal flags
// Rev 1.0
// ============================================================================
module dcache_req_counter
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int LS = 3
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [LS:0] o_count,
  output logic        o_last,
  output logic        o_term
);

  localparam int        W      = LS + 1;
  localparam logic [LS:0] c_full = W'(line_words(LS));
  localparam logic [LS:0] c_last = W'(line_words(LS) - 1);

  logic [LS:0] r_count;

  // Saturates at a full line so a stray increment can never wrap the offset
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != c_full)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;
  assign o_last  = (r_count == c_last);
  assign o_term  = (r_count == c_full);

endmodule
`default_nettype wire

// File: rtl/dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// dcache_miss_ctrl : dcache line-fill / single-word bypass Wishbone controller
// Rev 1.0
// ============================================================================
module dcache_miss_ctrl
  import dcache_miss_ctrl_pkg::*;
#(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int LS = 3
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_req,
  input  logic            i_cachable,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_data,
  input  logic [DW/8-1:0] i_sel,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_fill_we,
  output logic [LS-1:0]   o_fill_addr,
  output logic [DW-1:0]   o_fill_data,
  output logic            o_line_valid,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data
);

  state_e            r_state;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              r_lv;
  logic              r_cyc;
  logic              r_stb;
  logic              r_we;
  logic [AW-1:0]     r_addr;
  logic [DW-1:0]     r_wdata;
  logic [DW/8-1:0]   r_sel;
  logic [DW-1:0]     r_rdata;
  logic [LS-1:0]     r_off;

  logic              w_in_fill;
  logic              w_clr;
  logic              w_req_acc;
  logic              w_ack;
  logic              w_berr;
  logic [LS:0]       w_req_cnt;
  logic              w_req_last;
  logic              w_req_term;
  logic [LS:0]       w_ack_cnt;
  logic              w_ack_last;
  logic              w_ack_term;

  assign w_in_fill = (r_state == ST_FILL);
  assign w_clr     = (r_state == ST_IDLE);
  // Bus responses only count while a cycle is open
  assign w_req_acc = r_cyc && r_stb && !i_wb_stall;
  assign w_ack     = r_cyc && i_wb_ack && !i_wb_err;
  assign w_berr    = r_cyc && i_wb_err;

  dcache_req_counter #(.LS(LS)) u_req_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (w_clr),
    .i_inc     (w_in_fill && w_req_acc),
    .o_count   (w_req_cnt),
    .o_last    (w_req_last),
    .o_term    (w_req_term)
  );

  dcache_req_counter #(.LS(LS)) u_ack_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (w_clr),
    .i_inc     (w_in_fill && w_ack),
    .o_count   (w_ack_cnt),
    .o_last    (w_ack_last),
    .o_term    (w_ack_term)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_lv    <= 1'b0;
      r_cyc   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_rdata <= '0;
      r_off   <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_lv   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_req) begin
            r_busy <= 1'b1;
            r_cyc  <= 1'b1;
            r_stb  <= 1'b1;
            r_off  <= i_addr[LS-1:0];
            if (!i_we && i_cachable) begin
              r_state <= ST_FILL;
              r_addr  <= {i_addr[AW-1:LS], {LS{1'b0}}};
              r_we    <= 1'b0;
              r_wdata <= '0;
              r_sel   <= '1;
            end else begin
              r_state <= ST_SINGLE;
              r_addr  <= i_addr;
              r_we    <= i_we;
              r_wdata <= i_data;
              r_sel   <= i_sel;
            end
          end
        end

        ST_FILL: begin
          if (w_berr) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            if (w_req_acc && !w_req_term) begin
              r_addr <= r_addr + AW'(1);
              if (w_req_last) r_stb <= 1'b0;
            end
            if (w_ack && (w_ack_cnt[LS-1:0] == r_off)) r_rdata <= i_wb_data;
            if (w_ack && w_ack_last) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_lv    <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
        end

        ST_SINGLE: begin
          if (w_berr) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            if (w_req_acc) r_stb <= 1'b0;
            // An ack may land in the same cycle the strobe is accepted
            if (w_ack) begin
              r_cyc   <= 1'b0;
              r_stb   <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              if (!r_we) r_rdata <= i_wb_data;
            end
          end
        end

        default: begin
          r_cyc   <= 1'b0;
          r_stb   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Fill writes are a zero-latency passthrough of the bus read data
  assign o_fill_we    = w_in_fill && w_ack && !w_ack_term;
  assign o_fill_addr  = w_ack_cnt[LS-1:0];
  assign o_fill_data  = o_fill_we ? i_wb_data : '0;

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_line_valid = r_lv;
  assign o_rdata      = r_rdata;
  assign o_wb_cyc     = r_cyc;
  assign o_wb_stb     = r_stb;
  assign o_wb_we      = r_we;
  assign o_wb_addr    = r_addr;
  assign o_wb_data    = r_wdata;
  assign o_wb_sel     = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_dcache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// tb_dcache_miss_ctrl : directed bench with a pipelined Wishbone slave model
// Rev 1.0
// ============================================================================
module tb_dcache_miss_ctrl;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int LS = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req = 1'b0;
  logic            cachable = 1'b0;
  logic            we = 1'b0;
  logic [AW-1:0]   addr = '0;
  logic [DW-1:0]   data = '0;
  logic [DW/8-1:0] sel = '0;
  logic            wb_stall = 1'b0;
  logic            wb_ack = 1'b0;
  logic            wb_err = 1'b0;
  logic [DW-1:0]   wb_rdata = '0;

  logic            o_busy, o_done, o_err, o_fill_we, o_line_valid;
  logic [DW-1:0]   o_rdata, o_fill_data, o_wb_data;
  logic [LS-1:0]   o_fill_addr;
  logic            o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0]   o_wb_addr;
  logic [DW/8-1:0] o_wb_sel;

  always #5 clk = ~clk;

  dcache_miss_ctrl #(.AW(AW), .DW(DW), .LS(LS)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_req        (req),
    .i_cachable   (cachable),
    .i_we         (we),
    .i_addr       (addr),
    .i_data       (data),
    .i_sel        (sel),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_rdata      (o_rdata),
    .o_fill_we    (o_fill_we),
    .o_fill_addr  (o_fill_addr),
    .o_fill_data  (o_fill_data),
    .o_line_valid (o_line_valid),
    .o_wb_cyc     (o_wb_cyc),
    .o_wb_stb     (o_wb_stb),
    .o_wb_we      (o_wb_we),
    .o_wb_addr    (o_wb_addr),
    .o_wb_data    (o_wb_data),
    .o_wb_sel     (o_wb_sel),
    .i_wb_stall   (wb_stall),
    .i_wb_ack     (wb_ack),
    .i_wb_err     (wb_err),
    .i_wb_data    (wb_rdata)
  );

  int n_vec = 0;
  int n_fail = 0;

  // Slave configuration
  int          ack_delay = 1;
  bit          stall_alt = 1'b0;
  int          err_on_ack = 0;
  bit          rd_ovr = 1'b0;
  logic [31:0] rd_ovr_val = '0;

  typedef struct {
    int            due;
    logic [AW-1:0] a;
  } pend_t;
  pend_t pq[$];
  pend_t p_mon;
  pend_t p_drv;
  int    cyc_n = 0;
  int    ack_idx = 0;

  // Monitor records
  int            acc_cnt, fill_cnt, done_cnt, lv_cnt, err_cnt, extra_stb;
  int            done_cyc, lv_cyc;
  logic [AW-1:0] acc_addr[$];
  logic          acc_we_last;
  logic [3:0]    acc_sel_last;
  logic [31:0]   acc_data_last;
  logic [LS-1:0] fill_addr_q[$];
  logic [31:0]   fill_data_q[$];

  always @(negedge clk) begin
    if (o_wb_cyc && o_wb_stb && acc_cnt >= 8) extra_stb++;
    if (o_wb_cyc && o_wb_stb && !wb_stall) begin
      acc_cnt++;
      acc_addr.push_back(o_wb_addr);
      acc_we_last   = o_wb_we;
      acc_sel_last  = o_wb_sel;
      acc_data_last = o_wb_data;
      p_mon.due = cyc_n + ack_delay;
      p_mon.a   = o_wb_addr;
      pq.push_back(p_mon);
    end
    if (o_fill_we) begin
      fill_cnt++;
      fill_addr_q.push_back(o_fill_addr);
      fill_data_q.push_back(o_fill_data);
    end
    if (o_done) begin done_cnt++; done_cyc = cyc_n; end
    if (o_line_valid) begin lv_cnt++; lv_cyc = cyc_n; end
    if (o_err) err_cnt++;
  end

  // Responses are driven shortly after the active edge
  always @(posedge clk) begin
    cyc_n++;
    #2;
    wb_ack   = 1'b0;
    wb_err   = 1'b0;
    wb_rdata = '0;
    if (!o_wb_cyc) begin
      pq.delete();
      ack_idx = 0;
    end else if (pq.size() > 0 && pq[0].due <= cyc_n) begin
      p_drv = pq.pop_front();
      ack_idx++;
      if (ack_idx == err_on_ack) wb_err = 1'b1;
      else begin
        wb_ack   = 1'b1;
        wb_rdata = rd_ovr ? rd_ovr_val : {2'b10, p_drv.a};
      end
    end
    wb_stall = stall_alt ? cyc_n[0] : 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1);
  end

  task automatic clear_mon();
    acc_cnt = 0; fill_cnt = 0; done_cnt = 0; lv_cnt = 0; err_cnt = 0; extra_stb = 0;
    done_cyc = -1; lv_cyc = -2;
    acc_addr.delete(); fill_addr_q.delete(); fill_data_q.delete();
  endtask

  task automatic start_req(input logic c, input logic w, input logic [AW-1:0] a,
                           input logic [31:0] d, input logic [3:0] s);
    @(posedge clk); #2;
    req = 1'b1; cachable = c; we = w; addr = a; data = d; sel = s;
    @(posedge clk); #2;
    req = 1'b0; cachable = ~c; we = ~w; addr = ~a; data = ~d; sel = ~s;
  endtask

  task automatic wait_end(output bit gd, output bit ge);
    gd = 1'b0; ge = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (o_done || o_err) begin gd = o_done; ge = o_err; break; end
    end
    #1;
    if (!gd && !ge) begin
      n_vec++; n_fail++;
      $display("FAIL wait_end timeout: no o_done/o_err within 300 cycles");
    end
  endtask

  task automatic check_fill(input string nm, input logic [AW-1:0] base);
    bit ok_a, ok_f;
    ok_a = 1'b1; ok_f = 1'b1;
    for (int i = 0; i < acc_addr.size(); i++)
      if (acc_addr[i] !== base + AW'(i)) ok_a = 1'b0;
    for (int i = 0; i < fill_addr_q.size(); i++) begin
      if (fill_addr_q[i] !== LS'(i)) ok_f = 1'b0;
      if (fill_data_q[i] !== {2'b10, base + AW'(i)}) ok_f = 1'b0;
    end
    n_vec++; if (acc_cnt !== 8) begin n_fail++; $display("FAIL %s stb_count got %0d exp 8", nm, acc_cnt); end
    n_vec++; if (!ok_a) begin n_fail++; $display("FAIL %s stb_addrs got first %h exp seq from %h", nm, acc_addr[0], base); end
    n_vec++; if (fill_cnt !== 8) begin n_fail++; $display("FAIL %s fill_count got %0d exp 8", nm, fill_cnt); end
    n_vec++; if (!ok_f) begin n_fail++; $display("FAIL %s fill_addr_data got off0 %0d data0 %h exp sequential", nm, fill_addr_q[0], fill_data_q[0]); end
    n_vec++; if (done_cnt !== 1 || lv_cnt !== 1) begin n_fail++; $display("FAIL %s pulses got done %0d lv %0d exp 1 1", nm, done_cnt, lv_cnt); end
    n_vec++; if (lv_cyc !== done_cyc) begin n_fail++; $display("FAIL %s lv_with_done got lv@%0d done@%0d exp same", nm, lv_cyc, done_cyc); end
    n_vec++; if (err_cnt !== 0 || extra_stb !== 0) begin n_fail++; $display("FAIL %s err_extra got err %0d extra_stb %0d exp 0 0", nm, err_cnt, extra_stb); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_vec++; if ({o_busy, o_done, o_err, o_line_valid, o_wb_cyc, o_wb_stb, o_wb_we, o_fill_we} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl got %b exp 00000000", {o_busy, o_done, o_err, o_line_valid, o_wb_cyc, o_wb_stb, o_wb_we, o_fill_we}); end
    n_vec++; if (o_rdata !== 32'h0 || o_wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got rdata %h wbdata %h exp 0", o_rdata, o_wb_data); end
    n_vec++; if (o_wb_addr !== 30'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", o_wb_addr); end
    n_vec++; if (o_fill_addr !== 3'd0 || o_fill_data !== 32'h0) begin n_fail++; $display("FAIL reset_fill got %0d %h exp 0 0", o_fill_addr, o_fill_data); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fill_basic();
    bit gd, ge;
    clear_mon(); ack_delay = 1; stall_alt = 1'b0; err_on_ack = 0; rd_ovr = 1'b0;
    start_req(1'b1, 1'b0, 30'h0100_0005, 32'h0, 4'hF);
    wait_end(gd, ge);
    n_vec++; if ({gd, ge, o_busy, o_wb_cyc} !== 4'b1000) begin n_fail++; $display("FAIL fill_end got done,err,busy,cyc=%b exp 1000", {gd, ge, o_busy, o_wb_cyc}); end
    repeat (3) @(negedge clk); #1;
    check_fill("fill_basic", 30'h0100_0000);
    n_vec++; if (o_rdata !== 32'h8100_0005) begin n_fail++; $display("FAIL fill_basic_rdata got %h exp 81000005", o_rdata); end
  endtask

  task automatic test_fill_stall();
    bit gd, ge;
    clear_mon(); ack_delay = 3; stall_alt = 1'b1;
    start_req(1'b1, 1'b0, 30'h0100_0012, 32'h0, 4'hF);
    wait_end(gd, ge);
    repeat (3) @(negedge clk); #1;
    check_fill("fill_stall", 30'h0100_0010);
    n_vec++; if (o_rdata !== 32'h8100_0012) begin n_fail++; $display("FAIL fill_stall_rdata got %h exp 81000012", o_rdata); end
    ack_delay = 1; stall_alt = 1'b0;
  endtask

  task automatic test_uncached_read();
    bit gd, ge;
    clear_mon(); rd_ovr = 1'b1; rd_ovr_val = 32'hDEAD_BEEF;
    start_req(1'b0, 1'b0, 30'h0200_0000, 32'h0, 4'hF);
    wait_end(gd, ge);
    repeat (3) @(negedge clk); #1;
    n_vec++; if (acc_cnt !== 1 || acc_addr[0] !== 30'h0200_0000 || acc_we_last !== 1'b0) begin
      n_fail++; $display("FAIL unc_read_stb got cnt %0d addr %h we %b exp 1 02000000 0", acc_cnt, acc_addr[0], acc_we_last); end
    n_vec++; if (o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unc_read_rdata got %h exp deadbeef", o_rdata); end
    n_vec++; if (done_cnt !== 1 || lv_cnt !== 0 || fill_cnt !== 0) begin
      n_fail++; $display("FAIL unc_read_pulses got done %0d lv %0d fill %0d exp 1 0 0", done_cnt, lv_cnt, fill_cnt); end
    rd_ovr = 1'b0;
  endtask

  task automatic test_cached_write();
    bit gd, ge;
    clear_mon();
    start_req(1'b1, 1'b1, 30'h0300_0004, 32'h1234_5678, 4'b0011);
    wait_end(gd, ge);
    repeat (3) @(negedge clk); #1;
    n_vec++; if (acc_cnt !== 1 || acc_addr[0] !== 30'h0300_0004) begin
      n_fail++; $display("FAIL wr_stb got cnt %0d addr %h exp 1 03000004", acc_cnt, acc_addr[0]); end
    n_vec++; if ({acc_we_last, acc_sel_last} !== 5'b1_0011 || acc_data_last !== 32'h1234_5678) begin
      n_fail++; $display("FAIL wr_bus got we,sel %b data %h exp 10011 12345678", {acc_we_last, acc_sel_last}, acc_data_last); end
    n_vec++; if (done_cnt !== 1 || lv_cnt !== 0 || fill_cnt !== 0) begin
      n_fail++; $display("FAIL wr_pulses got done %0d lv %0d fill %0d exp 1 0 0", done_cnt, lv_cnt, fill_cnt); end
    n_vec++; if (o_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_rdata_kept got %h exp deadbeef", o_rdata); end
  endtask

  task automatic test_fill_err();
    bit gd, ge;
    clear_mon(); err_on_ack = 3;
    start_req(1'b1, 1'b0, 30'h0400_0001, 32'h0, 4'hF);
    wait_end(gd, ge);
    n_vec++; if ({gd, ge, o_busy, o_wb_cyc, o_wb_stb} !== 5'b01000) begin
      n_fail++; $display("FAIL err_end got done,err,busy,cyc,stb=%b exp 01000", {gd, ge, o_busy, o_wb_cyc, o_wb_stb}); end
    repeat (3) @(negedge clk); #1;
    n_vec++; if (err_cnt !== 1 || done_cnt !== 0 || lv_cnt !== 0) begin
      n_fail++; $display("FAIL err_pulses got err %0d done %0d lv %0d exp 1 0 0", err_cnt, done_cnt, lv_cnt); end
    n_vec++; if (fill_cnt !== 2) begin n_fail++; $display("FAIL err_fill_count got %0d exp 2", fill_cnt); end
    err_on_ack = 0;
    clear_mon(); rd_ovr = 1'b1; rd_ovr_val = 32'hCAFE_F00D;
    start_req(1'b0, 1'b0, 30'h0400_0100, 32'h0, 4'hF);
    wait_end(gd, ge);
    n_vec++; if (gd !== 1'b1 || o_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL err_next_req got done %b rdata %h exp 1 cafef00d", gd, o_rdata); end
    rd_ovr = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit gd, ge;
    clear_mon(); rd_ovr = 1'b1; rd_ovr_val = 32'h5555_AAAA;
    @(posedge clk); #2;
    req = 1'b1; cachable = 1'b0; we = 1'b0; addr = 30'h0500_0000; sel = 4'hF;
    wait_end(gd, ge);
    @(posedge clk); #2;
    req = 1'b0;
    n_vec++; if (o_busy !== 1'b1 || o_wb_cyc !== 1'b1) begin
      n_fail++; $display("FAIL b2b_reaccept got busy %b cyc %b exp 1 1", o_busy, o_wb_cyc); end
    wait_end(gd, ge);
    repeat (3) @(negedge clk); #1;
    n_vec++; if (acc_cnt !== 2 || done_cnt !== 2) begin
      n_fail++; $display("FAIL b2b_count got stb %0d done %0d exp 2 2", acc_cnt, done_cnt); end
    rd_ovr = 1'b0;
  endtask

  task automatic test_reset_midfill();
    bit gd, ge;
    clear_mon();
    start_req(1'b1, 1'b0, 30'h0600_0003, 32'h0, 4'hF);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (fill_cnt >= 4) break;
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if ({o_busy, o_wb_cyc, o_wb_stb, o_fill_we} !== 4'b0000 || o_rdata !== 32'h0) begin
      n_fail++; $display("FAIL async_reset got busy,cyc,stb,fwe=%b rdata %h exp 0000 0", {o_busy, o_wb_cyc, o_wb_stb, o_fill_we}, o_rdata); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_mon();
    start_req(1'b1, 1'b0, 30'h0600_0003, 32'h0, 4'hF);
    wait_end(gd, ge);
    repeat (3) @(negedge clk); #1;
    check_fill("post_reset_fill", 30'h0600_0000);
    n_vec++; if (o_rdata !== 32'h8600_0003) begin n_fail++; $display("FAIL post_reset_rdata got %h exp 86000003", o_rdata); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_fill_basic();
    test_fill_stall();
    test_uncached_read();
    test_cached_write();
    test_fill_err();
    test_back_to_back();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
Data-cache miss/bypass controller that consumes the per-address cachable decision and runs the bus side of the data cache. On a cachable read miss it performs a pipelined Wishbone line fill, writing each returned word into cache RAM. Uncachable reads and all writes (write-through) become single-word transactions. Sits between the dcache lookup stage, which supplies the request plus cachable flag, and the Wishbone master port.

Parameters:
AW, 30, word address width
DW, 32, data width
LS, 3, log2 of words per cache line (line = 2^LS words)

Ports:
i_clk  in  1  clock
i_reset_n  in  1  asynchronous active-low reset
i_req  in  1  request strobe from lookup stage; sampled only in IDLE
i_cachable  in  1  cachable decision for i_addr
i_we  in  1  1=write, 0=read
i_addr  in  AW  word address
i_data  in  DW  write data
i_sel  in  DW/8  byte selects
o_busy  out  1  high from accepted request until completion or error
o_done  out  1  one-cycle completion pulse
o_err  out  1  one-cycle bus-error pulse
o_rdata  out  DW  read data for single reads; requested word for fills
o_fill_we  out  1  cache RAM write strobe
o_fill_addr  out  LS  word offset within line for o_fill_we
o_fill_data  out  DW  data for o_fill_we
o_line_valid  out  1  one-cycle pulse: line fully filled, tag may be marked valid
o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master controls
o_wb_addr  out  AW  bus address
o_wb_data  out  DW  bus write data
o_wb_sel  out  DW/8  bus byte selects
i_wb_stall, i_wb_ack, i_wb_err  in  1 each  Wishbone slave responses
i_wb_data  in  DW  bus read data

Behaviour:
- Reset: i_reset_n low asynchronously forces IDLE; all 1-bit outputs 0, counters 0, o_rdata/o_wb_addr/o_wb_data/o_fill_* 0.
- States: IDLE, FILL, SINGLE.
- IDLE: i_req && !i_we && i_cachable -> FILL; i_req otherwise -> SINGLE. Next cycle o_busy=1, cyc=stb=1. Request latched, so i_* may change afterward.
- FILL: o_wb_addr starts at line base {i_addr[AW-1:LS], LS'b0}, o_wb_we=0, sel all ones. Each cycle stb&&!stall increments the request counter and the address. stb drops after 2^LS accepted requests. An independent ack counter (LS+1 bits) drives o_fill_addr, with o_fill_we=i_wb_ack and o_fill_data=i_wb_data in the same cycle (combinational passthrough, zero latency). The ack whose offset equals i_addr[LS-1:0] also registers into o_rdata. When ack count reaches 2^LS: cyc drops, o_done and o_line_valid pulse together the following cycle, then IDLE.
- SINGLE: one stb with latched we/addr/data/sel, held while stall. stb drops when accepted. On ack, cyc drops, o_rdata<=i_wb_data (reads only), o_done pulses next cycle, then IDLE. o_line_valid never pulses.
- Ack in same cycle as final stb acceptance is legal and counted.
- i_wb_err in any busy state: cyc and stb drop next edge, o_err pulses once, o_done and o_line_valid do not pulse, return to IDLE. Fill words already written stay in RAM but the line stays invalid.
- Ack/err received while cyc=0 are ignored.
- i_req while busy is ignored. The requester must hold off until o_done or o_err.
- o_busy deasserts in the same cycle o_done or o_err pulses, so a new request is accepted that cycle.

Decomposition:
- Shared package: state encoding (IDLE/FILL/SINGLE) and a LINE_WORDS = 1<<LS constant helper.
- Natural sub-module: dcache_req_counter, an LS+1-bit up-counter with clear and terminal flag, instantiated twice for the request and ack counts.
- Address decode stays outside. i_cachable comes from the lookup stage.

Test Plan:
- Cachable read, i_addr=30'h0100_0005, LS=3, no stall, ack 1 cycle after each stb -> 8 stbs at 0x0100_0000..0x0100_0007, o_fill_addr 0..7, o_rdata = 6th word, single o_line_valid and o_done pulse.
- Same fill with i_wb_stall high on every other cycle and acks delayed 3 cycles -> exactly 8 accepted stbs, 8 fill writes, no extra stb after 8th acceptance.
- Uncachable read at 30'h0200_0000 returning 32'hDEADBEEF -> one stb, o_rdata=32'hDEADBEEF, o_done pulse, o_line_valid stays 0.
- Cachable write, sel=4'b0011, data 32'h1234_5678 -> single stb with we=1, sel=4'b0011, no fill writes, o_done pulse.
- i_wb_err on 3rd ack of a fill -> cyc low next cycle, o_err pulse, no o_line_valid/o_done, returns IDLE, next request accepted.
- i_reset_n asserted mid-fill after 4 acks -> cyc/stb/o_busy 0 immediately (asynchronous), clean fill works after release.
